// File: rtl/ram_stream_reader.sv
// Streams a circular run of RAM words out through a 2-deep buffer; first beat 3 cycles after start.
// Reads are throttled so buffered plus in-flight words never exceed 2; valid_o holds data until ready_i.

module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
endmodule

module ram_stream_reader #(
  parameter int ITEM_COUNT = 800,
  parameter int DATA_WIDTH = 8,
  localparam int AddressWidth = $clog2(ITEM_COUNT),
  localparam int LengthWidth  = $clog2(ITEM_COUNT + 1)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [AddressWidth-1:0] start_address_i,
  input  logic [LengthWidth-1:0]  length_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ram_read_enable_o,
  output logic [AddressWidth-1:0] ram_read_address_o,
  input  logic [DATA_WIDTH-1:0]   ram_read_data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] address_q;
  logic [LengthWidth-1:0]  remaining_q;
  logic [LengthWidth-1:0]  clamped_length;
  logic                    inflight_q;
  logic                    inflight_last_q;
  logic                    run_end_q;
  logic                    accept;
  logic                    accept_run;
  logic                    issue;
  logic                    final_read;
  logic                    pop;
  logic [1:0]              fifo_count;
  logic [2:0]              occupancy;
  beat_t                   push_beat;
  beat_t                   head_beat;

  assign clamped_length = (length_i > LengthWidth'(ITEM_COUNT)) ? LengthWidth'(ITEM_COUNT) : length_i;
  assign accept         = (state_q == IDLE) && start_i;
  assign accept_run     = accept && (clamped_length != '0);

  assign valid_o = (fifo_count != 2'd0);
  assign pop     = valid_o && ready_i;
  assign data_o  = head_beat.data;
  assign last_o  = valid_o && head_beat.last;

  // Words already buffered or coming back from the RAM, less the one leaving this cycle.
  assign occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == READ) && (occupancy < 3'd2);
  assign final_read = issue && (remaining_q == LengthWidth'(1));

  assign ram_read_enable_o  = issue;
  assign ram_read_address_o = address_q;
  assign push_beat          = {inflight_last_q, ram_read_data_i};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_run) state_d = READ;
      READ:    if (final_read) state_d = DRAIN;
      DRAIN:   if (pop && head_beat.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      address_q       <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      run_end_q       <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= final_read;
      run_end_q       <= (state_q == DRAIN) && pop && head_beat.last;
      done_o          <= run_end_q || (accept && (clamped_length == '0));
      if (accept_run) begin
        address_q   <= start_address_i;
        remaining_q <= clamped_length;
      end else if (issue) begin
        address_q   <= (address_q == AddressWidth'(ITEM_COUNT - 1)) ? '0 : address_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      // A start taken in the same cycle the previous run retires keeps busy asserted.
      if (accept_run)     busy_o <= 1'b1;
      else if (run_end_q) busy_o <= 1'b0;
    end
  end

  stream_fifo #(
    .WIDTH($bits(beat_t)),
    .DEPTH(2)
  ) u_out_fifo (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .push     (inflight_q),
    .push_dat (push_beat),
    .pop      (pop),
    .head_dat (head_beat),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a RAM model preloaded with mem[a]=a[7:0] and a queue of expected beats.
module tb_ram_stream_reader;
  localparam int ItemCount    = 800;
  localparam int DataWidth    = 8;
  localparam int AddressWidth = $clog2(ItemCount);
  localparam int LengthWidth  = $clog2(ItemCount + 1);

  typedef struct {
    logic [DataWidth-1:0] data;
    logic                 last;
  } beat_t;

  logic                    clock_i = 1'b0;
  logic                    reset_i = 1'b1;
  logic                    start_i = 1'b0;
  logic [AddressWidth-1:0] start_address_i = '0;
  logic [LengthWidth-1:0]  length_i = '0;
  logic                    ready_i = 1'b1;
  logic [DataWidth-1:0]    ram_read_data_i = '0;
  logic                    busy_o, done_o, ram_read_enable_o, valid_o, last_o;
  logic [AddressWidth-1:0] ram_read_address_o;
  logic [DataWidth-1:0]    data_o;

  ram_stream_reader #(.ITEM_COUNT(ItemCount), .DATA_WIDTH(DataWidth)) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .start_i            (start_i),
    .start_address_i    (start_address_i),
    .length_i           (length_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .ram_read_enable_o  (ram_read_enable_o),
    .ram_read_address_o (ram_read_address_o),
    .ram_read_data_i    (ram_read_data_i),
    .data_o             (data_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .last_o             (last_o)
  );

  always #5 clock_i = ~clock_i;

  beat_t                exp_q[$];
  int                   beat_rel[$];
  int                   n_vec = 0, n_fail = 0;
  int                   cyc = 0, t0 = 0;
  int                   done_rel = -1, first_en_rel = -1;
  int                   done_cnt = 0, busy_cnt = 0, beats_seen = 0, ram_reads = 0;
  int                   done_snap = 0, busy_snap = 0, reads_snap = 0;
  bit                   rand_ready = 1'b0;
  logic                 stall_q = 1'b0;
  logic [DataWidth-1:0] stall_dat = '0;
  logic [DataWidth-1:0] mem [ItemCount];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(posedge clock_i) cyc <= cyc + 1;

  // RAM with one-cycle registered read
  initial for (int a = 0; a < ItemCount; a++) mem[a] = DataWidth'(a);
  always @(posedge clock_i) begin
    if (ram_read_enable_o) begin
      check("read_addr_in_range", 64'(ram_read_address_o < ItemCount), 1);
      ram_read_data_i <= mem[ram_read_address_o];
      ram_reads       <= ram_reads + 1;
    end
  end

  always @(posedge clock_i) begin
    #1;
    ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clock_i) begin
    beat_t e;
    if (reset_i) begin
      stall_q = 1'b0;
    end else begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        done_rel = cyc - t0 + 1;
      end
      if (ram_read_enable_o && first_en_rel < 0) first_en_rel = cyc - t0 + 1;
      if (stall_q) begin
        check("hold_valid", valid_o, 1);
        check("hold_data", data_o, stall_dat);
      end
      stall_q   = valid_o && !ready_i;
      stall_dat = data_o;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL extra_beat: got data %0d, expected no beat", data_o);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", data_o, e.data);
          check("beat_last", last_o, e.last);
          beat_rel.push_back(cyc - t0 + 1);
          beats_seen++;
        end
      end
    end
  end

  task automatic start_run(input int addr, input int len);
    int eff;
    @(posedge clock_i);
    #1;
    eff = (len > ItemCount) ? ItemCount : len;
    for (int i = 0; i < eff; i++)
      exp_q.push_back('{data: DataWidth'((addr + i) % ItemCount), last: (i == eff - 1)});
    reads_snap      = ram_reads;
    done_snap       = done_cnt;
    busy_snap       = busy_cnt;
    first_en_rel    = -1;
    done_rel        = -1;
    beat_rel.delete();
    start_i         = 1'b1;
    start_address_i = AddressWidth'(addr);
    length_i        = LengthWidth'(len);
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    t0      = cyc;
  endtask

  task automatic finish_run(input int eff, input int budget);
    int n = 0;
    while (done_cnt == done_snap && n < budget) begin
      @(negedge clock_i);
      n++;
    end
    repeat (3) @(negedge clock_i);
    check("done_pulses", done_cnt - done_snap, 1);
    check("beats_outstanding", exp_q.size(), 0);
    check("ram_reads", ram_reads - reads_snap, eff);
    check("busy_after_done", busy_o, 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs, n, addr, len;
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_last", last_o, 0);
    check("reset_read_en", ram_read_enable_o, 0);
    check("reset_read_addr", ram_read_address_o, 0);
    check("reset_data", data_o, 0);
    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;

    rand_ready = 1'b0;
    start_run(0, 4);
    finish_run(4, 50);
    check("basic_done_cycle", done_rel, 8);
    check("basic_first_read_cycle", first_en_rel, 1);
    check("basic_busy_cycles", busy_cnt - busy_snap, 7);
    check("basic_beat_count", beat_rel.size(), 4);
    for (int i = 0; i < beat_rel.size(); i++) check("basic_beat_cycle", beat_rel[i], 3 + i);

    start_run(798, 4);
    finish_run(4, 50);

    rand_ready = 1'b1;
    start_run($urandom_range(0, ItemCount - 1), 16);
    finish_run(16, 200);

    rand_ready = 1'b0;
    start_run(10, 0);
    finish_run(0, 20);
    check("zero_done_cycle", done_rel, 1);
    check("zero_busy_cycles", busy_cnt - busy_snap, 0);

    rand_ready = 1'b1;
    start_run(0, 900);
    repeat (10) @(posedge clock_i);
    #1;
    start_i         = 1'b1;
    start_address_i = AddressWidth'(5);
    length_i        = LengthWidth'(3);
    @(posedge clock_i);
    #1 start_i = 1'b0;
    finish_run(ItemCount, 5000);

    for (int r = 0; r < 6; r++) begin
      addr = $urandom_range(0, ItemCount - 1);
      len  = $urandom_range(1, 40);
      start_run(addr, len);
      finish_run(len, 400);
    end

    rand_ready = 1'b0;
    bs = beats_seen;
    start_run(100, 20);
    n = 0;
    while (beats_seen - bs < 6 && n < 50) begin
      @(negedge clock_i);
      n++;
    end
    check("abort_beats_before_reset", beats_seen - bs, 6);
    @(posedge clock_i);
    #1 reset_i = 1'b1;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_valid", valid_o, 0);
    check("abort_last", last_o, 0);
    check("abort_read_en", ram_read_enable_o, 0);
    check("abort_read_addr", ram_read_address_o, 0);
    check("abort_data", data_o, 0);
    exp_q.delete();
    done_snap = done_cnt;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
    repeat (4) @(negedge clock_i);
    check("abort_no_done", done_cnt - done_snap, 0);
    start_run(300, 5);
    finish_run(5, 50);
    check("after_abort_done_cycle", done_rel, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
